// File: rtl/button_debounce_pkg.sv
// ---------------------------------------------------------------------------
// button_debounce_pkg
//
// Shared definitions for the button debouncer. It provides:
//    state_t  - the four-state qualification FSM encoding. STABLE_LOW=00,
//               QUAL_HIGH=01, STABLE_HIGH=11 and QUAL_LOW=10, so bit 1 is
//               always the currently accepted level.
//    DEF_*    - default timing constants for a 10 MHz system clock.
//
// Optional feature macro in the importing design: BUTTON_DEBOUNCE_LONG_PRESS_EN.
// ---------------------------------------------------------------------------
package button_debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'b00,
      QUAL_HIGH   = 2'b01,
      STABLE_HIGH = 2'b11,
      QUAL_LOW    = 2'b10
   } state_t;

   // 10 ms of qualification and a 1 s long press at 10 MHz
   localparam int DEF_DEBOUNCE_CYCLES   = 100000;
   localparam int DEF_CNT_WIDTH         = 17;
   localparam int DEF_LONG_PRESS_CYCLES = 10000000;
   localparam int DEF_LONG_WIDTH        = 24;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//
// Generic two-flop synchroniser for an asynchronous pad input. There is no
// logic between the two flops, so the first stage has a full clock period
// to settle out of metastability. Both flops reset to RESET_VAL.
//
// Ports:
//    clock    in   system clock
//    reset_n  in   asynchronous active-low reset
//    raw      in   asynchronous input
//    synced   out  input synchronised to clock (two cycles of delay)
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic synced
);

   logic stage1;

   // Two back-to-back flops; the second one only ever samples the first.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stage1 <= RESET_VAL;
         synced <= RESET_VAL;
      end else begin
         stage1 <= raw;
         synced <= stage1;
      end
   end

endmodule

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//
// Turns a raw bouncing push-button into a clean, registered level plus
// single-cycle rise/fall strobes. A new level is accepted only after it has
// been seen for DEBOUNCE_CYCLES consecutive synchronised samples. Any bounce
// during qualification drops the FSM back to the old stable state, and the
// count restarts from zero.
//
// Optional feature: define BUTTON_DEBOUNCE_LONG_PRESS_EN to add a hold
// counter that pulses long_press once after the level has stayed high for
// LONG_PRESS_CYCLES cycles. Without the macro, long_press is tied to 0.
//
// Ports:
//    clock       in   system clock
//    reset_n     in   asynchronous assert, active-low reset
//    button      in   raw asynchronous pad input
//    level       out  debounced level (registered)
//    rise        out  one-cycle strobe on an accepted 0->1
//    fall        out  one-cycle strobe on an accepted 1->0
//    long_press  out  one-cycle strobe on a long hold
// ---------------------------------------------------------------------------
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_WIDTH         = DEF_CNT_WIDTH,
   parameter bit RESET_LEVEL       = 1'b0,
   parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
   parameter int LONG_WIDTH        = DEF_LONG_WIDTH
) (
   input  logic clock,
   input  logic reset_n,
   input  logic button,
   output logic level,
   output logic rise,
   output logic fall,
   output logic long_press
);

   localparam state_t              RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   // A zero or oversized qualification window cannot be counted.
   if (DEBOUNCE_CYCLES < 1 ||
       longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_WIDTH)) begin : g_bad_debounce
      $error("button_debounce: DEBOUNCE_CYCLES must be in 1..2**CNT_WIDTH");
   end

   // The long-press compare looks one count ahead, so it needs at least 2.
   if (LONG_PRESS_CYCLES < 2 ||
       longint'(LONG_PRESS_CYCLES) > (longint'(1) << LONG_WIDTH)) begin : g_bad_long
      $error("button_debounce: LONG_PRESS_CYCLES must be in 2..2**LONG_WIDTH");
   end

   logic                 s;
   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 level_q, level_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;

   sync_2ff #(
      .RESET_VAL (RESET_LEVEL)
   ) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (button),
      .synced  (s)
   );

   // State, counter and all outputs are registered together so that level
   // and its strobe change on the same edge and are glitch-free downstream.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
         level_q <= RESET_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Next-state logic. Strobes default low so they last exactly one cycle.
   // The counter only advances while qualifying and is cleared on every
   // state change, so it never passes CNT_LAST and never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE_LOW: begin
            if (s) begin
               state_d = QUAL_HIGH;
               cnt_d   = '0;
            end
         end
         QUAL_HIGH: begin
            if (!s) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         STABLE_HIGH: begin
            if (!s) begin
               state_d = QUAL_LOW;
               cnt_d   = '0;
            end
         end
         QUAL_LOW: begin
            if (s) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            state_d = RESET_STATE;
            cnt_d   = '0;
            level_d = RESET_LEVEL;
         end
      endcase
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
   localparam logic [LONG_WIDTH-1:0] HOLD_LAST = LONG_WIDTH'(LONG_PRESS_CYCLES - 1);
   localparam logic [LONG_WIDTH-1:0] HOLD_PRE  = LONG_WIDTH'(LONG_PRESS_CYCLES - 2);

   logic [LONG_WIDTH-1:0] hold_q;
   logic                  armed_q;
   logic                  long_press_q;

   // Hold counter: counts cycles spent in STABLE_HIGH and saturates at
   // HOLD_LAST. The strobe fires on the edge that reaches HOLD_LAST. The
   // armed flag is re-set only while level is low, so a bounce that falls
   // back from QUAL_LOW to STABLE_HIGH cannot produce a second pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold_q       <= '0;
         armed_q      <= 1'b1;
         long_press_q <= 1'b0;
      end else begin
         long_press_q <= 1'b0;
         if (state_q != STABLE_HIGH) begin
            hold_q <= '0;
         end else if (hold_q != HOLD_LAST) begin
            hold_q <= hold_q + LONG_WIDTH'(1);
         end
         if (state_q == STABLE_HIGH && hold_q == HOLD_PRE && armed_q) begin
            long_press_q <= 1'b1;
            armed_q      <= 1'b0;
         end else if (!level_q) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign long_press = long_press_q;
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_debounce
//
// Self-checking bench for button_debounce with DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20 and RESET_LEVEL=0. Each scenario pushes the expected
// {level, rise, fall, long_press} for every edge into a scoreboard queue and
// pops/compares after that edge. Inputs change 1 time unit after a rising
// edge; edge 1 is the first edge that sees a new button value.
// Long-press expectations follow BUTTON_DEBOUNCE_LONG_PRESS_EN.
// ---------------------------------------------------------------------------
module tb_button_debounce;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
   localparam bit LP_EN = 1'b1;
`else
   localparam bit LP_EN = 1'b0;
`endif

   logic clock;
   logic reset_n;
   logic button;
   logic level;
   logic rise;
   logic fall;
   logic long_press;

   logic [3:0] sb[$];
   logic [3:0] got;
   logic [3:0] exp_v;
   int         errors = 0;
   int         checks = 0;

   button_debounce #(
      .DEBOUNCE_CYCLES   (4),
      .CNT_WIDTH         (4),
      .RESET_LEVEL       (1'b0),
      .LONG_PRESS_CYCLES (20),
      .LONG_WIDTH        (8)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .button     (button),
      .level      (level),
      .rise       (rise),
      .fall       (fall),
      .long_press (long_press)
   );

   // 10-unit clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case anything stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive button, let one rising edge happen, settle 1 unit past it
   task automatic tick(input logic b);
      button = b;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      button  = 1'b0;
      #1;
      for (int k = 1; k <= 10; k++) begin
         sb.push_back(4'b0000);
         tick(k[0]);
         got   = {level, rise, fall, long_press};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("[TB] FAIL reset_hold k=%0d got=%b required=%b", k, got, exp_v);
         end
      end
      button  = 1'b0;
      reset_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         sb.push_back(4'b0000);
         tick(1'b0);
         got   = {level, rise, fall, long_press};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("[TB] FAIL reset_idle k=%0d got=%b required=%b", k, got, exp_v);
         end
      end
   endtask

   task automatic test_clean_press();
      for (int k = 1; k <= 10; k++) begin
         sb.push_back({k >= 7, k == 7, 1'b0, 1'b0});
         tick(1'b1);
         got   = {level, rise, fall, long_press};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("[TB] FAIL clean_press k=%0d got=%b required=%b", k, got, exp_v);
         end
      end
   endtask

   task automatic test_clean_release();
      for (int k = 1; k <= 10; k++) begin
         sb.push_back({k < 7, 1'b0, k == 7, 1'b0});
         tick(1'b0);
         got   = {level, rise, fall, long_press};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("[TB] FAIL clean_release k=%0d got=%b required=%b", k, got, exp_v);
         end
      end
   endtask

   // 1,1,1,0 then 1 held: final 0->1 is seen at edge 5, rise at edge 11
   task automatic test_bounce();
      for (int k = 1; k <= 14; k++) begin
         sb.push_back({k >= 11, k == 11, 1'b0, 1'b0});
         tick(k != 4);
         got   = {level, rise, fall, long_press};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("[TB] FAIL bounce k=%0d got=%b required=%b", k, got, exp_v);
         end
      end
   endtask

   // Reset lands at QUAL_HIGH with cnt=2, then qualification restarts
   task automatic test_reset_mid_qual();
      for (int k = 1; k <= 5; k++) begin
         sb.push_back(4'b0000);
         tick(1'b1);
         got   = {level, rise, fall, long_press};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("[TB] FAIL midqual_pre k=%0d got=%b required=%b", k, got, exp_v);
         end
      end
      reset_n = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         sb.push_back(4'b0000);
         tick(1'b1);
         got   = {level, rise, fall, long_press};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("[TB] FAIL midqual_reset k=%0d got=%b required=%b", k, got, exp_v);
         end
      end
      reset_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         sb.push_back({k >= 7, k == 7, 1'b0, 1'b0});
         tick(1'b1);
         got   = {level, rise, fall, long_press};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("[TB] FAIL midqual_post k=%0d got=%b required=%b", k, got, exp_v);
         end
      end
   endtask

   // Two long holds; level rises at edge 7 and the 20th cycle in
   // STABLE_HIGH starts at edge 26
   task automatic test_long_press();
      for (int p = 1; p <= 2; p++) begin
         for (int k = 1; k <= 47; k++) begin
            sb.push_back({k >= 7, k == 7, 1'b0, LP_EN && (k == 26)});
            tick(1'b1);
            got   = {level, rise, fall, long_press};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("[TB] FAIL long_press p=%0d k=%0d got=%b required=%b", p, k, got, exp_v);
            end
         end
         for (int k = 1; k <= 10; k++) begin
            sb.push_back({k < 7, 1'b0, k == 7, 1'b0});
            tick(1'b0);
            got   = {level, rise, fall, long_press};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("[TB] FAIL long_release p=%0d k=%0d got=%b required=%b", p, k, got, exp_v);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_clean_release();
      test_bounce();
      test_clean_release();
      test_reset_mid_qual();
      test_clean_release();
      test_long_press();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
